lane_unstripe_sched: RTL

Scheduler that sits in front of the byte un-striping datapath: it buffers bytes arriving on two lanes in per-lane FIFOs, waits until both lanes hold data (lane alignment/deskew), then drains them strictly alternately, lane 0 first, onto one byte stream. It stalls rather than reorders when the next lane is empty. It flags overflow and, optionally, a stall timeout. It runs entirely in the fast (2f) domain.

---
 rtl/lane_unstripe_sched_pkg.sv | 19 +
 rtl/lane_unstripe_sched_fifo.sv | 60 ++++++
 rtl/lane_unstripe_sched.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lane_unstripe_sched_pkg.sv
`default_nettype none
// ============================================================================
// unstripe_pkg : shared types and constants for the lane un-striping scheduler
// Revision     : 1.0  initial release
// ============================================================================
package unstripe_pkg;

   localparam int BYTE_W = 8;

   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

   typedef enum logic [0:0] {
      ALIGN = 1'b0,
      RUN   = 1'b1
   } state_t;

endpackage : unstripe_pkg
`default_nettype wire

// File: rtl/lane_unstripe_sched_fifo.sv
`default_nettype none
// ============================================================================
// lane_fifo : per-lane synchronous FIFO; a pop frees its slot for a write on
//             the same edge, so a full FIFO can pop and accept together.
// Revision  : 1.0  initial release
// ============================================================================
module lane_fifo
   import unstripe_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = BYTE_W
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [W-1:0]           wr_data,
   input  logic                   rd_en,
   output logic [W-1:0]           rd_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic          w_do_rd;
   logic          w_do_wr;
   logic [AW:0]   w_eff_count;

   assign w_do_rd     = rd_en && (r_count != '0);
   assign w_eff_count = r_count - {{AW{1'b0}}, w_do_rd};
   assign w_do_wr     = wr_en && (w_eff_count < c_FULL);

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= r_count + {{AW{1'b0}}, w_do_wr} - {{AW{1'b0}}, w_do_rd};
      end
   end

   assign rd_data = r_mem[r_rd_ptr];
   assign count   = r_count;

endmodule : lane_fifo
`default_nettype wire

// File: rtl/lane_unstripe_sched.sv
`default_nettype none
// ============================================================================
// lane_unstripe_sched : buffers two byte lanes, aligns them, then drains them
//                       strictly alternately (lane 0 first) onto one stream.
//                       Optional stall timeout: define UNSTRIPE_TIMEOUT_EN.
// Revision            : 1.0  initial release
// ============================================================================
module lane_unstripe_sched
   import unstripe_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic              clk_2f,
   input  logic              reset,
   input  logic [BYTE_W-1:0] lane_0,
   input  logic              valid_0,
   input  logic [BYTE_W-1:0] lane_1,
   input  logic              valid_1,
   output logic [BYTE_W-1:0] data_out,
   output logic              valid_out,
   output logic              aligned,
   output logic              overflow,
   output logic              timeout_err
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

   if (TIMEOUT > 255 || DEPTH < 2) begin : g_param_range_bad
   end

   state_t            r_state;
   logic              r_sel;
   logic [BYTE_W-1:0] r_data;
   logic              r_valid;
   logic              r_overflow;

   logic [CW-1:0]     w_cnt0;
   logic [CW-1:0]     w_cnt1;
   logic [BYTE_W-1:0] w_head0;
   logic [BYTE_W-1:0] w_head1;
   logic              w_ne0;
   logic              w_ne1;
   logic              w_cur_ne;
   logic              w_end;
   logic              w_timeout;
   logic              w_flush;
   logic              w_pop;
   logic              w_pop0;
   logic              w_pop1;
   logic              w_ovf;

   assign w_ne0    = (w_cnt0 != '0);
   assign w_ne1    = (w_cnt1 != '0);
   assign w_cur_ne = (r_sel == LANE0) ? w_ne0 : w_ne1;

   // A burst only ends on a completed pair: sel back at lane 0 with nothing left.
   assign w_end  = (r_state == RUN) && (r_sel == LANE0) && !w_ne0 && !w_ne1;
   assign w_pop  = (r_state == RUN) && !w_end && !w_timeout && w_cur_ne;
   assign w_pop0 = w_pop && (r_sel == LANE0);
   assign w_pop1 = w_pop && (r_sel == LANE1);

   assign w_ovf = (valid_0 && (w_cnt0 == c_FULL) && !w_pop0) ||
                  (valid_1 && (w_cnt1 == c_FULL) && !w_pop1);

`ifdef UNSTRIPE_TIMEOUT_EN
   logic [7:0] r_stall_cnt;
   logic       r_timeout_err;

   assign w_timeout = (r_state == RUN) && (r_stall_cnt == 8'(TIMEOUT));

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         r_stall_cnt   <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end
         if ((r_state != RUN) || w_end || w_timeout || w_pop) begin
            r_stall_cnt <= '0;
         end else if (r_stall_cnt != 8'hFF) begin
            r_stall_cnt <= r_stall_cnt + 8'd1;
         end
      end
   end

   assign timeout_err = r_timeout_err;
`else
   assign w_timeout   = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign w_flush = w_timeout;

   lane_fifo #(
      .DEPTH   (DEPTH),
      .W       (BYTE_W)
   ) u_fifo0 (
      .clk     (clk_2f),
      .rst     (reset),
      .flush   (w_flush),
      .wr_en   (valid_0),
      .wr_data (lane_0),
      .rd_en   (w_pop0),
      .rd_data (w_head0),
      .count   (w_cnt0)
   );

   lane_fifo #(
      .DEPTH   (DEPTH),
      .W       (BYTE_W)
   ) u_fifo1 (
      .clk     (clk_2f),
      .rst     (reset),
      .flush   (w_flush),
      .wr_en   (valid_1),
      .wr_data (lane_1),
      .rd_en   (w_pop1),
      .rd_data (w_head1),
      .count   (w_cnt1)
   );

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         r_state    <= ALIGN;
         r_sel      <= LANE0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (w_ovf) begin
            r_overflow <= 1'b1;
         end
         case (r_state)
            ALIGN: begin
               r_valid <= 1'b0;
               if (w_ne0 && w_ne1) begin
                  r_state <= RUN;
                  r_sel   <= LANE0;
               end
            end
            RUN: begin
               if (w_end) begin
                  r_state <= ALIGN;
                  r_valid <= 1'b0;
               end else if (w_timeout) begin
                  r_state <= ALIGN;
                  r_sel   <= LANE0;
                  r_valid <= 1'b0;
               end else if (w_pop) begin
                  r_data  <= (r_sel == LANE0) ? w_head0 : w_head1;
                  r_valid <= 1'b1;
                  r_sel   <= ~r_sel;
               end else begin
                  // Stall: hold data_out, wait for the lane whose turn it is.
                  r_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= ALIGN;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign data_out  = r_data;
   assign valid_out = r_valid;
   assign aligned   = (r_state == RUN);
   assign overflow  = r_overflow;

endmodule : lane_unstripe_sched
`default_nettype wire
